pe_array_feeder: RTL and testbench
==================================

// Module: pe_array_feeder
// PURPOSE
//  Sequencer driving the pe_array control/data ports. Reads activation rows and a weight stream from
//  1-cycle-latency sync-read buffers and issues one clear beat plus K MAC beats per output tile.
//  Presents each tile's PE results to a downstream writer with a valid/ready handshake.
// PARAMETERS
//  MAC_NUM  10  PE lanes; activations per buffer row
//  BW_ACT   8   activation width
//  BW_WET   8   weight width
//  AW       10  buffer address width
//  KW       10  width of cfg_k_len / cfg_tile_num
// PORTS
//  clk              in   1               clock, rising edge
//  reset            in   1               asynchronous, active-high reset
//  start            in   1               one-cycle pulse; sampled only in IDLE
//  cfg_k_len        in   KW              MAC beats per tile (K); latched on start
//  cfg_tile_num     in   KW              tiles per run (T); latched on start
//  cfg_shift        in   8               result shift; latched on start
//  act_rd_en        out  1               activation buffer read enable
//  act_rd_addr      out  AW              activation row address = k
//  act_rd_data      in   MAC_NUM*BW_ACT  row; lane i = [i*BW_ACT +: BW_ACT]; valid 1 cycle after rd_en
//  wet_rd_en        out  1               weight buffer read enable
//  wet_rd_addr      out  AW              weight address = t*K + k (truncated to AW)
//  wet_rd_data      in   BW_WET          weight, valid 1 cycle after rd_en
//  PE_mac_enable    out  1               to pe_array
//  PE_clear_acc     out  1               to pe_array
//  PE_act_out       out  BW_ACT x MAC_NUM  unpacked [MAC_NUM-1:0], signed, to PE_act_in
//  PE_wet_out       out  BW_WET          signed, to PE_wet_in
//  PE_res_shift_num out  8               latched cfg_shift
//  res_valid        out  1               PE_result_out holds tile res_tile_idx
//  res_ready        in   1               downstream has captured results
//  res_tile_idx     out  KW              current tile t
//  busy             out  1               high in every state except IDLE
//  done             out  1               one-cycle pulse after last tile handshake
// BEHAVIOUR
//  - Reset: all outputs 0, FSM -> IDLE, counters 0. Reset mid-run aborts; no done pulse.
//  - FSM: IDLE -> CLEAR (on start, T>0); IDLE -> DONE (on start, T==0).
//    CLEAR -> FEED (K>0); CLEAR -> DRAIN (K==0).
//    FEED (K cycles) -> DRAIN (2 cycles) -> RESULT.
//    RESULT -> CLEAR when res_ready && t<T-1; RESULT -> DONE when res_ready && t==T-1.
//    DONE (1 cycle, done=1) -> IDLE.
//  - CLEAR (cycle D-1): PE_clear_acc=1, act/wet outputs 0, rd_en=1 with k=0 if K>0.
//  - FEED beat k (cycle D+k): PE_act_out/PE_wet_out = rd_data.
//    rd_en=1 with address k+1 while k+1<K; rd_en=0 otherwise.
//  - Outside FEED, PE_act_out/PE_wet_out are forced to 0.
//  - PE_mac_enable = (CLEAR|FEED) registered 1 cycle: high cycles D..D+K, 0 elsewhere.
//    Matches pe_array's internal 1-cycle data/clear register.
//  - Final accumulation at end of D+K; pe_array output register valid from D+K+2.
//    res_valid rises in cycle D+K+2 (first RESULT cycle).
//  - res_valid held, res_tile_idx stable until res_ready; transfer on res_valid&&res_ready.
//    res_ready while !res_valid is ignored.
//  - Backpressure: no new clear issued until transfer, so PE results stay stable through RESULT.
//  - start while busy ignored. cfg_* changes after start have no effect on the running job.
//  - Counters: k in 0..K-1, t in 0..T-1. Weight address wraps modulo 2^AW (no error flag).
//  - Tile cost with ready tied high: K+4 cycles (CLEAR + K FEED + 2 DRAIN + 1 RESULT).
// STRUCTURE
//  - pe_pkg: state enum (IDLE,CLEAR,FEED,DRAIN,RESULT,DONE), default widths BW_ACT/BW_WET, DRAIN_CYC=2.
//  - Single module; no sub-module. Row unpacking is a generate loop.
// TESTING
//  - K=3,T=1, act row k lanes = k+1, weights {2,-1,3}, ready=1, shift=0:
//    -> PE_result_out every lane i: 2*1-1*2+3*3 = 9; res_valid exactly cycle D+5.
//  - K=4,T=2, ready low 5 cycles in tile 0:
//    -> res_valid held 6 cycles, tile 1 CLEAR only after transfer; wet addresses 0..3 then 4..7.
//  - K=0,T=1 -> one clear + one enable cycle, results 0, done after handshake.
//    T=0 -> done one cycle after start, busy high 1 cycle, no rd_en.
//  - Acts 127, weights 127, K=2, shift=0:
//    -> pe_array saturates to 127. Shift=8 -> 126 (32258>>>8).
//  - Reset asserted during FEED of tile 1:
//    -> all outputs 0 immediately, IDLE; new start runs cleanly from tile 0.
//  - start pulsed in FEED/RESULT -> ignored; cfg change mid-run -> no effect.

Source files
------------

// File: rtl/pe_array_feeder_pkg.sv
// Shared types and default widths for the PE array feeder.
package pe_array_feeder_pkg;

    localparam int unsigned DEF_MAC_NUM = 10;
    localparam int unsigned DEF_BW_ACT  = 8;
    localparam int unsigned DEF_BW_WET  = 8;
    localparam int unsigned DEF_AW      = 10;
    localparam int unsigned DEF_KW      = 10;
    // Cycles between the last MAC beat and the PE output register being valid.
    localparam int unsigned DRAIN_CYC   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StResult,
        StDone
    } state_e;

endpackage

// File: rtl/pe_array_feeder_if.sv
// Control, buffer-read, PE and result-handshake signals of the feeder.
interface pe_array_feeder_if
    import pe_array_feeder_pkg::*;
#(
    parameter int unsigned MAC_NUM = DEF_MAC_NUM,
    parameter int unsigned BW_ACT  = DEF_BW_ACT,
    parameter int unsigned BW_WET  = DEF_BW_WET,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned KW      = DEF_KW
);
    logic                          start;
    logic [KW-1:0]                 cfg_k_len;
    logic [KW-1:0]                 cfg_tile_num;
    logic [7:0]                    cfg_shift;
    logic                          act_rd_en;
    logic [AW-1:0]                 act_rd_addr;
    logic [MAC_NUM*BW_ACT-1:0]     act_rd_data;
    logic                          wet_rd_en;
    logic [AW-1:0]                 wet_rd_addr;
    logic [BW_WET-1:0]             wet_rd_data;
    logic                          PE_mac_enable;
    logic                          PE_clear_acc;
    logic signed [BW_ACT-1:0]      PE_act_out [MAC_NUM-1:0];
    logic signed [BW_WET-1:0]      PE_wet_out;
    logic [7:0]                    PE_res_shift_num;
    logic                          res_valid;
    logic                          res_ready;
    logic [KW-1:0]                 res_tile_idx;
    logic                          busy;
    logic                          done;

    modport master (
        input  start, cfg_k_len, cfg_tile_num, cfg_shift, act_rd_data, wet_rd_data, res_ready,
        output act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr, PE_mac_enable, PE_clear_acc,
               PE_act_out, PE_wet_out, PE_res_shift_num, res_valid, res_tile_idx, busy, done
    );

    modport slave (
        output start, cfg_k_len, cfg_tile_num, cfg_shift, act_rd_data, wet_rd_data, res_ready,
        input  act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr, PE_mac_enable, PE_clear_acc,
               PE_act_out, PE_wet_out, PE_res_shift_num, res_valid, res_tile_idx, busy, done
    );

endinterface

// File: rtl/pe_array_feeder.sv
// Tile sequencer: one clear beat plus K MAC beats per tile, then a valid/ready result hand-off.
module pe_array_feeder
    import pe_array_feeder_pkg::*;
#(
    parameter int unsigned MAC_NUM = DEF_MAC_NUM,
    parameter int unsigned BW_ACT  = DEF_BW_ACT,
    parameter int unsigned BW_WET  = DEF_BW_WET,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned KW      = DEF_KW
) (
    input  logic              clk,
    input  logic              reset,
    pe_array_feeder_if.master bus
);

    localparam int unsigned SW = (AW > KW) ? AW : KW;
    localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DrainLast = DW'(DRAIN_CYC - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d, t_q, t_d;
    logic [KW-1:0] k_len_q, k_len_d, tiles_q, tiles_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          mac_en_q;

    logic [KW:0]   k_inc, t_inc;
    logic [KW-1:0] rd_k;
    logic [SW-1:0] rd_k_ext, k_len_ext;
    logic          rd_en, feed;

    assign k_inc     = {1'b0, k_q} + {{KW{1'b0}}, 1'b1};
    assign t_inc     = {1'b0, t_q} + {{KW{1'b0}}, 1'b1};
    assign k_len_ext = SW'(k_len_q);
    assign rd_k_ext  = SW'(rd_k);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        k_len_d = k_len_q;
        tiles_d = tiles_q;
        shift_d = shift_q;
        base_d  = base_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        rd_k    = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    k_len_d = bus.cfg_k_len;
                    tiles_d = bus.cfg_tile_num;
                    shift_d = bus.cfg_shift;
                    k_d     = '0;
                    t_d     = '0;
                    base_d  = '0;
                    state_d = (bus.cfg_tile_num != '0) ? StClear : StDone;
                end
            end
            StClear: begin
                rd_en   = (k_len_q != '0);
                k_d     = '0;
                drain_d = '0;
                state_d = rd_en ? StFeed : StDrain;
            end
            StFeed: begin
                // Prefetch row k+1 while beat k is on the PE inputs.
                rd_en = (k_inc < {1'b0, k_len_q});
                rd_k  = k_inc[KW-1:0];
                if (rd_en) begin
                    k_d = k_inc[KW-1:0];
                end else begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DrainLast) begin
                    state_d = StResult;
                end
            end
            StResult: begin
                // Holding here keeps the next clear away from the PE results until transfer.
                if (bus.res_ready) begin
                    if (t_inc == {1'b0, tiles_q}) begin
                        state_d = StDone;
                    end else begin
                        t_d     = t_inc[KW-1:0];
                        base_d  = base_q + k_len_ext[AW-1:0];
                        state_d = StClear;
                    end
                end
            end
            StDone: begin
                t_d     = '0;
                base_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            t_q      <= '0;
            k_len_q  <= '0;
            tiles_q  <= '0;
            shift_q  <= '0;
            base_q   <= '0;
            drain_q  <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            t_q      <= t_d;
            k_len_q  <= k_len_d;
            tiles_q  <= tiles_d;
            shift_q  <= shift_d;
            base_q   <= base_d;
            drain_q  <= drain_d;
            // pe_array registers clear/data one cycle, so the enable lags by one as well.
            mac_en_q <= (state_q == StClear) || (state_q == StFeed);
        end
    end

    assign feed                 = (state_q == StFeed);
    assign bus.act_rd_en        = rd_en;
    assign bus.wet_rd_en        = rd_en;
    assign bus.act_rd_addr      = rd_en ? rd_k_ext[AW-1:0] : '0;
    assign bus.wet_rd_addr      = rd_en ? base_q + rd_k_ext[AW-1:0] : '0;
    assign bus.PE_mac_enable    = mac_en_q;
    assign bus.PE_clear_acc     = (state_q == StClear);
    assign bus.PE_wet_out       = feed ? bus.wet_rd_data : '0;
    assign bus.PE_res_shift_num = shift_q;
    assign bus.res_valid        = (state_q == StResult);
    assign bus.res_tile_idx     = t_q;
    assign bus.busy             = (state_q != StIdle);
    assign bus.done             = (state_q == StDone);

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        assign bus.PE_act_out[i] = feed ? bus.act_rd_data[i*BW_ACT +: BW_ACT] : '0;
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder with sync-read buffers and a behavioural pe_array.
module tb_pe_array_feeder;

    localparam int unsigned MAC_NUM = 10;
    localparam int unsigned BW_ACT  = 8;
    localparam int unsigned BW_WET  = 8;
    localparam int unsigned AW      = 10;
    localparam int unsigned KW      = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pe_array_feeder_if #(
        .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_WET(BW_WET), .AW(AW), .KW(KW)
    ) bus ();

    pe_array_feeder #(
        .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_WET(BW_WET), .AW(AW), .KW(KW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [MAC_NUM*BW_ACT-1:0] act_mem [1024];
    logic [BW_WET-1:0]         wet_mem [1024];
    logic [AW-1:0]             wet_log [256];
    int                        wet_n = 0;

    always @(posedge clk) begin
        if (bus.act_rd_en) bus.act_rd_data <= act_mem[bus.act_rd_addr];
        if (bus.wet_rd_en) begin
            bus.wet_rd_data         <= wet_mem[bus.wet_rd_addr];
            wet_log[wet_n[7:0]]     <= bus.wet_rd_addr;
            wet_n                   <= wet_n + 1;
        end
    end

    // Behavioural pe_array: registered clear/data, accumulate on enable, saturating output reg.
    logic                     pa_clear_q;
    logic signed [BW_ACT-1:0] pa_act_q [MAC_NUM];
    logic signed [BW_WET-1:0] pa_wet_q;
    logic signed [31:0]       pa_acc   [MAC_NUM];
    logic signed [7:0]        pa_res   [MAC_NUM];

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) return 8'sd127;
        if (v < -32'sd128) return -8'sd128;
        return v[7:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pa_clear_q <= 1'b0;
            pa_wet_q   <= '0;
            for (int i = 0; i < MAC_NUM; i++) begin
                pa_act_q[i] <= '0;
                pa_acc[i]   <= '0;
                pa_res[i]   <= '0;
            end
        end else begin
            pa_clear_q <= bus.PE_clear_acc;
            pa_wet_q   <= bus.PE_wet_out;
            for (int i = 0; i < MAC_NUM; i++) begin
                pa_act_q[i] <= bus.PE_act_out[i];
                if (bus.PE_mac_enable)
                    pa_acc[i] <= (pa_clear_q ? 32'sd0 : pa_acc[i]) + 32'(pa_act_q[i]) * 32'(pa_wet_q);
                pa_res[i] <= sat8(pa_acc[i] >>> bus.PE_res_shift_num);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the caller at the first negedge after start was sampled (the CLEAR cycle).
    task automatic start_job(input int k, input int t, input int s);
        bus.cfg_k_len    = KW'(k);
        bus.cfg_tile_num = KW'(t);
        bus.cfg_shift    = 8'(s);
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
    endtask

    task automatic load_row(input int addr, input int val);
        logic [MAC_NUM*BW_ACT-1:0] row;
        for (int i = 0; i < MAC_NUM; i++) row[i*BW_ACT +: BW_ACT] = BW_ACT'(val);
        act_mem[addr] = row;
    endtask

    task automatic load_basic();
        for (int k = 0; k < 3; k++) load_row(k, k + 1);
        wet_mem[0] = 8'd2;
        wet_mem[1] = 8'hFF;
        wet_mem[2] = 8'd3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b res_valid=%b, want 0 0 0",
                     bus.busy, bus.done, bus.res_valid);
        end
        n_checks++;
        if (bus.PE_mac_enable !== 1'b0 || bus.PE_clear_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pe_ctrl: mac=%b clear=%b, want 0 0",
                     bus.PE_mac_enable, bus.PE_clear_acc);
        end
        n_checks++;
        if (bus.act_rd_en !== 1'b0 || bus.wet_rd_en !== 1'b0 || bus.res_tile_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_rd: act_en=%b wet_en=%b tile=%0d, want 0 0 0",
                     bus.act_rd_en, bus.wet_rd_en, bus.res_tile_idx);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int bad;
        load_basic();
        bus.res_ready = 1'b1;
        start_job(3, 1, 0);
        n_checks++;
        if (bus.PE_clear_acc !== 1'b1 || bus.act_rd_en !== 1'b1 || bus.act_rd_addr !== '0) begin
            n_fail++;
            $display("FAIL basic_clear: clear=%b rd_en=%b addr=%0d, want 1 1 0",
                     bus.PE_clear_acc, bus.act_rd_en, bus.act_rd_addr);
        end
        for (int n = 2; n <= 9; n++) begin
            step();
            if (n == 2) begin
                n_checks++;
                if (bus.PE_act_out[0] !== 8'sd1 || bus.PE_wet_out !== 8'sd2 ||
                    bus.PE_mac_enable !== 1'b1 || bus.wet_rd_addr !== 10'd1) begin
                    n_fail++;
                    $display("FAIL basic_beat0: act=%0d wet=%0d mac=%b waddr=%0d, want 1 2 1 1",
                             bus.PE_act_out[0], bus.PE_wet_out, bus.PE_mac_enable,
                             bus.wet_rd_addr);
                end
            end
            if (n == 6) begin
                n_checks++;
                if (bus.res_valid !== 1'b0 || bus.PE_mac_enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early: res_valid=%b mac=%b, want 0 0",
                             bus.res_valid, bus.PE_mac_enable);
                end
            end
            if (n == 7) begin
                n_checks++;
                if (bus.res_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_res_valid: got %b want 1", bus.res_valid);
                end
                bad = 0;
                for (int i = 0; i < MAC_NUM; i++) if (pa_res[i] !== 8'sd9) bad++;
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL basic_result: lane0=%0d bad_lanes=%0d, want 9", pa_res[0], bad);
                end
            end
            if (n == 8) begin
                n_checks++;
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_done: got %b want 1", bus.done);
                end
            end
            if (n == 9) begin
                n_checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int w0, held, bad_idx, bad_clr, bad_addr;
        for (int k = 0; k < 4; k++) load_row(k, 1);
        for (int a = 0; a < 8; a++) wet_mem[a] = 8'(a + 1);
        bus.res_ready = 1'b0;
        w0 = wet_n;
        held = 0;
        bad_idx = 0;
        bad_clr = 0;
        start_job(4, 2, 0);
        for (int n = 2; n <= 23; n++) begin
            step();
            if (n >= 8 && n <= 13) begin
                if (bus.res_valid === 1'b1) held++;
                if (bus.res_tile_idx !== '0) bad_idx++;
                if (bus.PE_clear_acc !== 1'b0) bad_clr++;
            end
            if (n == 8) begin
                n_checks++;
                if (pa_res[0] !== 8'sd10) begin
                    n_fail++;
                    $display("FAIL bp_tile0_result: got %0d want 10", pa_res[0]);
                end
            end
            if (n == 13) bus.res_ready = 1'b1;
            if (n == 14) begin
                n_checks++;
                if (bus.PE_clear_acc !== 1'b1 || bus.res_tile_idx !== 10'd1 ||
                    bus.res_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_tile1_clear: clear=%b tile=%0d res_valid=%b, want 1 1 0",
                             bus.PE_clear_acc, bus.res_tile_idx, bus.res_valid);
                end
            end
            if (n == 21) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || pa_res[0] !== 8'sd26) begin
                    n_fail++;
                    $display("FAIL bp_tile1_result: res_valid=%b res=%0d, want 1 26",
                             bus.res_valid, pa_res[0]);
                end
            end
            if (n == 22) begin
                n_checks++;
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_done: got %b want 1", bus.done);
                end
            end
        end
        n_checks++;
        if (held != 6 || bad_idx != 0 || bad_clr != 0) begin
            n_fail++;
            $display("FAIL bp_hold: valid_cycles=%0d idx_err=%0d clr_err=%0d, want 6 0 0",
                     held, bad_idx, bad_clr);
        end
        bad_addr = 0;
        for (int j = 0; j < 8; j++) if (wet_log[8'(w0 + j)] !== AW'(j)) bad_addr++;
        n_checks++;
        if (wet_n - w0 != 8 || bad_addr != 0) begin
            n_fail++;
            $display("FAIL bp_wet_addr: reads=%0d bad=%0d, want 8 0", wet_n - w0, bad_addr);
        end
    endtask

    task automatic test_k_zero();
        int mac_cnt, clr_cnt, rd_cnt;
        bus.res_ready = 1'b1;
        mac_cnt = 0;
        clr_cnt = 0;
        rd_cnt  = 0;
        start_job(0, 1, 0);
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) step();
            if (bus.PE_mac_enable === 1'b1) mac_cnt++;
            if (bus.PE_clear_acc === 1'b1) clr_cnt++;
            if (bus.act_rd_en === 1'b1 || bus.wet_rd_en === 1'b1) rd_cnt++;
            if (n == 4) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || pa_res[0] !== 8'sd0) begin
                    n_fail++;
                    $display("FAIL k0_result: res_valid=%b res=%0d, want 1 0",
                             bus.res_valid, pa_res[0]);
                end
            end
            if (n == 5) begin
                n_checks++;
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL k0_done: got %b want 1", bus.done);
                end
            end
        end
        n_checks++;
        if (mac_cnt != 1 || clr_cnt != 1 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL k0_counts: mac=%0d clear=%0d rd=%0d, want 1 1 0",
                     mac_cnt, clr_cnt, rd_cnt);
        end
    endtask

    task automatic test_t_zero();
        start_job(5, 0, 0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.act_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL t0_done: done=%b busy=%b rd_en=%b, want 1 1 0",
                     bus.done, bus.busy, bus.act_rd_en);
        end
        step();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t0_idle: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_saturate();
        int bad;
        load_row(0, 127);
        load_row(1, 127);
        wet_mem[0] = 8'd127;
        wet_mem[1] = 8'd127;
        bus.res_ready = 1'b1;
        start_job(2, 1, 0);
        for (int n = 2; n <= 6; n++) step();
        bad = 0;
        for (int i = 0; i < MAC_NUM; i++) if (pa_res[i] !== 8'sd127) bad++;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bad != 0) begin
            n_fail++;
            $display("FAIL sat_shift0: res_valid=%b lane0=%0d bad=%0d, want 1 127 0",
                     bus.res_valid, pa_res[0], bad);
        end
        step();
        step();
        start_job(2, 1, 8);
        n_checks++;
        if (bus.PE_res_shift_num !== 8'd8) begin
            n_fail++;
            $display("FAIL sat_shift_out: got %0d want 8", bus.PE_res_shift_num);
        end
        for (int n = 2; n <= 6; n++) step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || pa_res[0] !== 8'sd126) begin
            n_fail++;
            $display("FAIL sat_shift8: res_valid=%b res=%0d, want 1 126",
                     bus.res_valid, pa_res[0]);
        end
        step();
        step();
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        for (int k = 0; k < 4; k++) load_row(k, 1);
        for (int a = 0; a < 8; a++) wet_mem[a] = 8'(a + 1);
        bus.res_ready = 1'b1;
        done_seen = 0;
        start_job(4, 2, 3);
        for (int n = 2; n <= 11; n++) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        n_checks++;
        if (bus.res_tile_idx !== 10'd1 || bus.PE_mac_enable !== 1'b1 || bus.act_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_feed: tile=%0d mac=%b rd_en=%b, want 1 1 1",
                     bus.res_tile_idx, bus.PE_mac_enable, bus.act_rd_en);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.PE_mac_enable !== 1'b0 || bus.act_rd_en !== 1'b0 ||
            bus.PE_act_out[0] !== '0 || bus.PE_wet_out !== '0 || bus.res_tile_idx !== '0 ||
            bus.PE_res_shift_num !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: busy=%b mac=%b rd=%b act=%0d wet=%0d tile=%0d sh=%0d",
                     bus.busy, bus.PE_mac_enable, bus.act_rd_en, bus.PE_act_out[0],
                     bus.PE_wet_out, bus.res_tile_idx, bus.PE_res_shift_num);
        end
        step();
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_done: done pulses=%0d want 0", done_seen);
        end
        load_basic();
        start_job(3, 1, 0);
        n_checks++;
        if (bus.res_tile_idx !== '0 || bus.wet_rd_addr !== '0 || bus.PE_clear_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart: tile=%0d waddr=%0d clear=%b, want 0 0 1",
                     bus.res_tile_idx, bus.wet_rd_addr, bus.PE_clear_acc);
        end
        for (int n = 2; n <= 7; n++) step();
        n_checks++;
        if (bus.res_valid !== 1'b1 || pa_res[0] !== 8'sd9) begin
            n_fail++;
            $display("FAIL rst_rerun_result: res_valid=%b res=%0d, want 1 9",
                     bus.res_valid, pa_res[0]);
        end
        step();
        step();
    endtask

    task automatic test_ignore_start_cfg();
        load_basic();
        bus.res_ready = 1'b1;
        start_job(3, 1, 0);
        for (int n = 2; n <= 9; n++) begin
            step();
            if (n == 3) begin
                bus.cfg_k_len    = 10'd7;
                bus.cfg_tile_num = 10'd3;
                bus.cfg_shift    = 8'd4;
                bus.start        = 1'b1;
            end
            if (n == 4) bus.start = 1'b0;
            if (n == 7) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || pa_res[0] !== 8'sd9 ||
                    bus.PE_res_shift_num !== 8'd0) begin
                    n_fail++;
                    $display("FAIL ign_result: res_valid=%b res=%0d shift=%0d, want 1 9 0",
                             bus.res_valid, pa_res[0], bus.PE_res_shift_num);
                end
                bus.start = 1'b1;
            end
            if (n == 8) begin
                bus.start = 1'b0;
                n_checks++;
                if (bus.done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ign_done: got %b want 1", bus.done);
                end
            end
            if (n == 9) begin
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ign_idle: busy=%b want 0", bus.busy);
                end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.cfg_k_len    = '0;
        bus.cfg_tile_num = '0;
        bus.cfg_shift    = '0;
        bus.res_ready    = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_k_zero();
        test_t_zero();
        test_saturate();
        test_reset_midrun();
        test_ignore_start_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
